// File: rtl/skolem_sweep_checker.sv
// skolem_sweep_checker
// Exhaustively walks every NIN-bit input vector through an external
// combinational Skolem circuit and a golden reference circuit, one vector
// per clock. It counts disagreements and remembers the lowest failing vector.
// Optional feature macro: SKOLEM_SWEEP_CARE_EN. When defined, it adds the
// care_in input so that only constrained vectors are compared.
module skolem_sweep_checker #(
    parameter int NIN = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic [NIN-1:0] vec_out,
    input  logic           sk_in,
    input  logic           gold_in,
`ifdef SKOLEM_SWEEP_CARE_EN
    input  logic           care_in,
`endif
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [NIN:0]   mismatch_cnt,
    output logic [NIN-1:0] first_fail_vec,
    output logic           first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [NIN:0]   vecIdx_q;
    logic [NIN:0]   vecIdx_d;
    logic [NIN:0]   mismatchCnt_q;
    logic [NIN:0]   mismatchCnt_d;
    logic [NIN-1:0] firstFailVec_q;
    logic           firstFailValid_q;
    logic           busy_q;
    logic           done_q;
    logic           pass_q;
    logic           isMismatch;

    // Compare the circuit outputs for the vector on vec_out, then form the next index and count.
    always_comb begin
`ifdef SKOLEM_SWEEP_CARE_EN
        isMismatch = (sk_in != gold_in) && care_in;
`else
        isMismatch = (sk_in != gold_in);
`endif
        vecIdx_d      = vecIdx_q + {{NIN{1'b0}}, 1'b1};
        mismatchCnt_d = mismatchCnt_q + {{NIN{1'b0}}, isMismatch};
    end

    // Sweep state machine. The index MSB flags that the last vector has been compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            vecIdx_q         <= '0;
            mismatchCnt_q    <= '0;
            firstFailVec_q   <= '0;
            firstFailValid_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q          <= RUN;
                        vecIdx_q         <= '0;
                        mismatchCnt_q    <= '0;
                        firstFailVec_q   <= '0;
                        firstFailValid_q <= 1'b0;
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                    end
                end
                RUN: begin
                    vecIdx_q <= vecIdx_d;
                    if (isMismatch) begin
                        mismatchCnt_q <= mismatchCnt_d;
                        if (!firstFailValid_q) begin
                            firstFailVec_q   <= vecIdx_q[NIN-1:0];
                            firstFailValid_q <= 1'b1;
                        end
                    end
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (vecIdx_d[NIN]) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (mismatchCnt_d == '0);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_out          = vecIdx_q[NIN-1:0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_cnt     = mismatchCnt_q;
    assign first_fail_vec   = firstFailVec_q;
    assign first_fail_valid = firstFailValid_q;

endmodule
